// File: rtl/mem_sram_stage.sv
// Memory stage: 32-bit loads/stores over a 16-bit SRAM as two halfword phases.
// Optional feature macro: MEM_POSTED_WRITE_EN (one-entry posted store buffer).
module mem_sram_stage #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               WB_EN,
  input  logic               MEM_R,
  input  logic               MEM_W,
  input  logic [31:0]        ALU_res,
  input  logic [31:0]        val_rm,
  input  logic [3:0]         dest,
  output logic               freeze,
  output logic               WB_EN_out,
  output logic               MEM_R_out,
  output logic [31:0]        ALU_res_out,
  output logic [31:0]        mem_data_out,
  output logic [3:0]         dest_out,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned   CW     = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST   = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] PENULT = CW'(WAIT_CYCLES - 2);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

`ifdef MEM_POSTED_WRITE_EN
  localparam state_t AFTER_WR = IDLE;
`else
  localparam state_t AFTER_WR = DONE;
`endif

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [31:0]        data;
  logic [SRAM_AW-1:0] hi_addr;
  logic [15:0]        wdata_hi;

  logic [29:0]        word;
  logic [SRAM_AW-1:0] lo_addr_c;
  logic [SRAM_AW-1:0] hi_addr_c;
  logic               req;

  assign word      = 30'((ALU_res - 32'(ADDR_BASE)) >> 2);
  assign lo_addr_c = SRAM_AW'({word, 1'b0});
  assign hi_addr_c = SRAM_AW'({word, 1'b1});
  assign req       = MEM_R | MEM_W;

  // A posted store accepted in IDLE does not stall; everything else stalls until DONE.
`ifdef MEM_POSTED_WRITE_EN
  assign freeze = req & (state != DONE) & ~((state == IDLE) & MEM_W);
`else
  assign freeze = req & (state != DONE);
`endif

  // Access sequencer; SRAM strobes are registered from the transition into each phase cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      data       <= '0;
      hi_addr    <= '0;
      wdata_hi   <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt      <= '0;
          hi_addr  <= hi_addr_c;
          wdata_hi <= val_rm[31:16];
          if (MEM_W) begin
            state      <= WR_LO;
            sram_addr  <= lo_addr_c;
            sram_wdata <= val_rm[15:0];
            sram_we_n  <= 1'b0;
          end else if (MEM_R) begin
            state     <= RD_LO;
            sram_addr <= lo_addr_c;
            sram_oe_n <= 1'b0;
          end
        end
        RD_LO, RD_HI: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (state == RD_LO) begin
              data[15:0] <= sram_rdata;
              sram_addr  <= hi_addr;
              state      <= RD_HI;
            end else begin
              data[31:16] <= sram_rdata;
              sram_oe_n   <= 1'b1;
              state       <= DONE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WR_LO, WR_HI: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (state == WR_LO) begin
              sram_addr  <= hi_addr;
              sram_wdata <= wdata_hi;
              sram_we_n  <= 1'b0;
              state      <= WR_HI;
            end else begin
              sram_we_n <= 1'b1;
              state     <= AFTER_WR;
            end
          end else begin
            cnt       <= cnt + CW'(1);
            sram_we_n <= (cnt == PENULT);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble while frozen, capture otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      WB_EN_out    <= 1'b0;
      MEM_R_out    <= 1'b0;
      ALU_res_out  <= '0;
      mem_data_out <= '0;
      dest_out     <= '0;
    end else if (freeze) begin
      WB_EN_out <= 1'b0;
      MEM_R_out <= 1'b0;
    end else begin
      WB_EN_out    <= WB_EN;
      MEM_R_out    <= MEM_R;
      ALU_res_out  <= ALU_res;
      dest_out     <= dest;
      mem_data_out <= (MEM_R & ~MEM_W) ? data : 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_sram_stage.sv
// Randomized bench for mem_sram_stage with a transaction-level timing/memory model.
module tb_mem_sram_stage;
  localparam int W = 5;
`ifdef MEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        WB_EN = 1'b0, MEM_R = 1'b0, MEM_W = 1'b0;
  logic [31:0] ALU_res = '0, val_rm = '0;
  logic [3:0]  dest = '0;
  logic        freeze, WB_EN_out, MEM_R_out, sram_we_n, sram_oe_n;
  logic [31:0] ALU_res_out, mem_data_out;
  logic [3:0]  dest_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;

  mem_sram_stage #(.ADDR_BASE(1024), .SRAM_AW(18), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .WB_EN(WB_EN), .MEM_R(MEM_R), .MEM_W(MEM_W),
    .ALU_res(ALU_res), .val_rm(val_rm), .dest(dest), .freeze(freeze),
    .WB_EN_out(WB_EN_out), .MEM_R_out(MEM_R_out), .ALU_res_out(ALU_res_out),
    .mem_data_out(mem_data_out), .dest_out(dest_out), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n));

  always #5 clk = ~clk;

  // External SRAM
  logic [15:0] sram [0:(1<<18)-1];
  assign sram_rdata = sram[sram_addr];
  always @(posedge clk) if (sram_we_n === 1'b0) sram[sram_addr] <= sram_wdata;

  typedef struct {bit we_n; bit oe_n; bit wr; logic [17:0] addr; logic [15:0] wdata;} ent_t;
  ent_t sched[$];
  logic [31:0] ref_mem [int unsigned];

  int total = 0, bad = 0;
  int fz_cnt = 0, we_lo = 0, oe_lo = 0;
  bit chk_en = 1'b0;
  bit exp_freeze, exp_we, exp_oe, exp_wb, exp_mr;
  logic [17:0] exp_addr;
  logic [15:0] exp_wdata;
  logic [31:0] exp_alu, exp_md, cur_ld;
  logic [3:0]  exp_dest;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned key(input logic [31:0] a);
    logic [31:0] wi;
    wi = (a - 32'd1024) >> 2;
    return wi & 32'h1FFFF;
  endfunction

  function automatic logic [17:0] hw_lo(input logic [31:0] a);
    logic [31:0] wi;
    wi = (a - 32'd1024) >> 2;
    return 18'(wi * 2);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(key(a)) ? ref_mem[key(a)] : 32'h0;
  endfunction

  // Two halfword phases of W cycles each; stores release we_n on the last cycle of a phase.
  task automatic push_phases(input logic [17:0] lo, input bit wr, input logic [31:0] rm);
    ent_t e;
    for (int p = 0; p < 2*W; p++) begin
      e.addr  = (p < W) ? lo : lo + 18'd1;
      e.wr    = wr;
      e.wdata = (p < W) ? rm[15:0] : rm[31:16];
      e.we_n  = !(wr && (p % W) != W-1);
      e.oe_n  = wr;
      sched.push_back(e);
    end
  endtask

  // One clock cycle: publish this cycle's expectations, then apply the output-register rule.
  task automatic cyc(input bit fz);
    ent_t e;
    exp_freeze = fz;
    if (sched.size() > 0) begin
      e = sched.pop_front();
      exp_we = e.we_n; exp_oe = e.oe_n; exp_addr = e.addr;
      if (e.wr) exp_wdata = e.wdata;
    end else begin
      exp_we = 1'b1; exp_oe = 1'b1;
    end
    @(posedge clk);
    if (!rst_n) begin
      sched.delete();
      exp_wb = 0; exp_mr = 0; exp_alu = '0; exp_md = '0; exp_dest = '0;
      exp_addr = '0; exp_wdata = '0; exp_we = 1'b1; exp_oe = 1'b1;
    end else if (fz) begin
      exp_wb = 0; exp_mr = 0;
    end else begin
      exp_wb = WB_EN; exp_mr = MEM_R; exp_alu = ALU_res; exp_dest = dest;
      exp_md = (MEM_R && !MEM_W) ? cur_ld : 32'h0;
    end
    #1;
  endtask

  task automatic do_op(input bit wb, input bit r, input bit w, input logic [31:0] alu,
                       input logic [31:0] rm, input logic [3:0] d, input int abort_at);
    logic [17:0] lo;
    WB_EN = wb; MEM_R = r; MEM_W = w; ALU_res = alu; val_rm = rm; dest = d;
    cur_ld = (r && !w) ? ref_rd(alu) : 32'h0;
    lo = hw_lo(alu);
    if (!(r || w)) begin cyc(1'b0); return; end
`ifdef MEM_POSTED_WRITE_EN
    while (sched.size() > 0) cyc(1'b1);
    if (w) begin
      cyc(1'b0);
      push_phases(lo, 1'b1, rm);
      ref_mem[key(alu)] = rm;
      return;
    end
`endif
    for (int t = 0; t <= 2*W; t++) begin
      if (t == abort_at) begin
        rst_n = 1'b0; cyc(1'b1); rst_n = 1'b1;
        return;
      end
      cyc(1'b1);
      if (t == 0) push_phases(lo, w, rm);
    end
    cyc(1'b0);
    if (w) ref_mem[key(alu)] = rm;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, -1);
  endtask

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("freeze", 32'(freeze), 32'(exp_freeze));
      chk("sram_we_n", 32'(sram_we_n), 32'(exp_we));
      chk("sram_oe_n", 32'(sram_oe_n), 32'(exp_oe));
      chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
      chk("sram_wdata", 32'(sram_wdata), 32'(exp_wdata));
      chk("WB_EN_out", 32'(WB_EN_out), 32'(exp_wb));
      chk("MEM_R_out", 32'(MEM_R_out), 32'(exp_mr));
      chk("ALU_res_out", ALU_res_out, exp_alu);
      chk("dest_out", 32'(dest_out), 32'(exp_dest));
      chk("mem_data_out", mem_data_out, exp_md);
      if (freeze) fz_cnt++;
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
    end
  end

  initial begin
    int kind;
    logic [31:0] a;
    for (int i = 0; i < (1<<18); i++) sram[i] = 16'h0;
    exp_addr = '0; exp_wdata = '0; cur_ld = '0;
    cyc(1'b0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    chk("rst_WB_EN_out", 32'(WB_EN_out), 32'h0);
    chk("rst_mem_data_out", mem_data_out, 32'h0);

    // Non-memory op
    fz_cnt = 0;
    do_op(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd3, -1);
    chk("nonmem_freeze_cycles", 32'(fz_cnt), 32'd0);
    chk("nonmem_ALU_res_out", ALU_res_out, 32'h1234);
    chk("nonmem_dest_out", 32'(dest_out), 32'd3);
    chk("nonmem_WB_EN_out", 32'(WB_EN_out), 32'd1);

    // Store 0xDEADBEEF to word 2, then load it back
    fz_cnt = 0; we_lo = 0;
    do_op(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd1, -1);
    chk("store_freeze_cycles", 32'(fz_cnt), POSTED ? 32'd0 : 32'd11);
    chk("store_WB_EN_out", 32'(WB_EN_out), 32'd0);
    fz_cnt = 0;
    do_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd5, -1);
    chk("load_freeze_cycles", 32'(fz_cnt), POSTED ? 32'd21 : 32'd11);
    chk("load_mem_data_out", mem_data_out, 32'hDEADBEEF);
    chk("load_MEM_R_out", 32'(MEM_R_out), 32'd1);
    chk("store_we_low_cycles", 32'(we_lo), 32'd8);
    chk("sram_hw4", 32'(sram[4]), 32'h0000BEEF);
    chk("sram_hw5", 32'(sram[5]), 32'h0000DEAD);

    // MEM_R and MEM_W together act as a store
    we_lo = 0; oe_lo = 0;
    do_op(1'b1, 1'b1, 1'b1, 32'd1024 + 32'h40, 32'h01234567, 4'd7, -1);
    idle(2*W + 2);
    chk("both_oe_low_cycles", 32'(oe_lo), 32'd0);
    chk("both_we_low_cycles", 32'(we_lo), 32'd8);
    chk("both_sram_lo", 32'(sram[32]), 32'h00004567);

    // Reset in the second cycle of RD_HI
    do_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd2, W + 2);
    chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
    chk("abort_sram_addr", 32'(sram_addr), 32'd0);
    chk("abort_ALU_res_out", ALU_res_out, 32'd0);

`ifdef MEM_POSTED_WRITE_EN
    fz_cnt = 0;
    do_op(1'b0, 1'b0, 1'b1, 32'd1024 + 32'h80, 32'hCAFEF00D, 4'd1, -1);
    do_op(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd4, -1);
    chk("posted_pair_freeze", 32'(fz_cnt), 32'd0);
    do_op(1'b1, 1'b1, 1'b0, 32'd1024 + 32'h80, 32'h0, 4'd6, -1);
    chk("posted_load_freeze", 32'(fz_cnt), 32'd20);
    chk("posted_load_data", mem_data_out, 32'hCAFEF00D);
`endif

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = $urandom();
      else a = 32'd1024 + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
      if (kind < 4)
        do_op(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom(), $urandom(), 4'($urandom_range(0, 15)), -1);
      else if (kind < 7)
        do_op(1'($urandom_range(0, 1)), kind == 6 && $urandom_range(0, 3) == 0, 1'b1, a, $urandom(),
              4'($urandom_range(0, 15)), -1);
      else
        do_op(1'b1, 1'b1, 1'b0, a, $urandom(), 4'($urandom_range(0, 15)), -1);
    end
    idle(2*W + 2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
